// File: rtl/dram_responder.sv
// Memory-side responder: turns one 32-bit word request into two 16-bit
// strobed accesses on an asynchronous SRAM-style bus, then pulses completion.
module dram_responder #(
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_read,
  input  logic        req_write,
  output logic [31:0] rd_data,
  output logic        data_valid,
  output logic        write_complete,
  output logic        busy,
  output logic [24:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_dq_oe,
  input  logic [15:0] mem_rdata,
  output logic        mem_cs_n,
  output logic        mem_oe_n,
  output logic        mem_we_n
);

  typedef enum logic [2:0] {
    IDLE, HI_STROBE, HI_RECOVER, LO_STROBE, LO_RECOVER, DONE, RELEASE
  } state_t;

  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

  state_t      state_q, state_d;
  logic        op_q, op_d;  // 1 = write
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] wdata_lo_q, wdata_lo_d;
  logic [24:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        mem_dq_oe_q, mem_dq_oe_d;
  logic        mem_cs_n_q, mem_cs_n_d;
  logic        mem_oe_n_q, mem_oe_n_d;
  logic        mem_we_n_q, mem_we_n_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        data_valid_q, data_valid_d;
  logic        write_complete_q, write_complete_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d          = state_q;
    op_d             = op_q;
    cnt_d            = cnt_q;
    wdata_lo_d       = wdata_lo_q;
    mem_addr_d       = mem_addr_q;
    mem_wdata_d      = mem_wdata_q;
    mem_dq_oe_d      = mem_dq_oe_q;
    mem_cs_n_d       = mem_cs_n_q;
    mem_oe_n_d       = mem_oe_n_q;
    mem_we_n_d       = mem_we_n_q;
    rd_data_d        = rd_data_q;
    data_valid_d     = 1'b0;
    write_complete_d = 1'b0;

    case (state_q)
      IDLE: begin
        // Write wins a tie; a pending read is picked up after RELEASE.
        if (req_write || req_read) begin
          op_d       = req_write;
          mem_addr_d = {req_addr, 1'b0};
          mem_cs_n_d = 1'b0;
          cnt_d      = WS_INIT;
          state_d    = HI_STROBE;
          if (req_write) begin
            mem_we_n_d  = 1'b0;
            mem_dq_oe_d = 1'b1;
            mem_wdata_d = req_wdata[31:16];
            wdata_lo_d  = req_wdata[15:0];
          end else begin
            mem_oe_n_d  = 1'b0;
          end
        end
      end
      HI_STROBE: begin
        if (cnt_q == 4'd0) begin
          mem_oe_n_d = 1'b1;
          mem_we_n_d = 1'b1;
          if (!op_q) rd_data_d[31:16] = mem_rdata;
          state_d    = HI_RECOVER;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HI_RECOVER: begin
        mem_addr_d[0] = 1'b1;
        cnt_d         = WS_INIT;
        state_d       = LO_STROBE;
        if (op_q) begin
          mem_we_n_d  = 1'b0;
          mem_wdata_d = wdata_lo_q;
        end else begin
          mem_oe_n_d  = 1'b0;
        end
      end
      LO_STROBE: begin
        if (cnt_q == 4'd0) begin
          mem_oe_n_d = 1'b1;
          mem_we_n_d = 1'b1;
          if (!op_q) rd_data_d[15:0] = mem_rdata;
          state_d    = LO_RECOVER;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      LO_RECOVER: begin
        mem_cs_n_d       = 1'b1;
        mem_dq_oe_d      = 1'b0;
        data_valid_d     = !op_q;
        write_complete_d = op_q;
        state_d          = DONE;
      end
      DONE: state_d = RELEASE;
      RELEASE: begin
        // Hold off until the initiator drops the request we just completed.
        if (op_q ? !req_write : !req_read) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      op_q             <= 1'b0;
      cnt_q            <= 4'd0;
      wdata_lo_q       <= 16'd0;
      mem_addr_q       <= 25'd0;
      mem_wdata_q      <= 16'd0;
      mem_dq_oe_q      <= 1'b0;
      mem_cs_n_q       <= 1'b1;
      mem_oe_n_q       <= 1'b1;
      mem_we_n_q       <= 1'b1;
      rd_data_q        <= 32'd0;
      data_valid_q     <= 1'b0;
      write_complete_q <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      op_q             <= op_d;
      cnt_q            <= cnt_d;
      wdata_lo_q       <= wdata_lo_d;
      mem_addr_q       <= mem_addr_d;
      mem_wdata_q      <= mem_wdata_d;
      mem_dq_oe_q      <= mem_dq_oe_d;
      mem_cs_n_q       <= mem_cs_n_d;
      mem_oe_n_q       <= mem_oe_n_d;
      mem_we_n_q       <= mem_we_n_d;
      rd_data_q        <= rd_data_d;
      data_valid_q     <= data_valid_d;
      write_complete_q <= write_complete_d;
      busy_q           <= busy_d;
    end
  end

  assign rd_data        = rd_data_q;
  assign data_valid     = data_valid_q;
  assign write_complete = write_complete_q;
  assign busy           = busy_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_dq_oe      = mem_dq_oe_q;
  assign mem_cs_n       = mem_cs_n_q;
  assign mem_oe_n       = mem_oe_n_q;
  assign mem_we_n       = mem_we_n_q;

endmodule

// File: tb/tb_dram_responder.sv
// Bench for dram_responder: two instances (WAIT_STATES=2 and 0) against an
// SRAM pin model and a word-level reference memory.
module tb_dram_responder;

  logic        clk;
  logic        rst;
  logic [23:0] req_addr[2];
  logic [31:0] req_wdata[2];
  logic        req_read[2];
  logic        req_write[2];
  logic [31:0] rd_data[2];
  logic        data_valid[2];
  logic        write_complete[2];
  logic        busy[2];
  logic [24:0] mem_addr[2];
  logic [15:0] mem_wdata[2];
  logic        mem_dq_oe[2];
  logic [15:0] mem_rdata[2];
  logic        mem_cs_n[2];
  logic        mem_oe_n[2];
  logic        mem_we_n[2];

  dram_responder #(.WAIT_STATES(2)) dut_ws2 (
    .clk(clk), .rst(rst),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_read(req_read[0]), .req_write(req_write[0]),
    .rd_data(rd_data[0]), .data_valid(data_valid[0]),
    .write_complete(write_complete[0]), .busy(busy[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_dq_oe(mem_dq_oe[0]),
    .mem_rdata(mem_rdata[0]), .mem_cs_n(mem_cs_n[0]),
    .mem_oe_n(mem_oe_n[0]), .mem_we_n(mem_we_n[0])
  );

  dram_responder #(.WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .rst(rst),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_read(req_read[1]), .req_write(req_write[1]),
    .rd_data(rd_data[1]), .data_valid(data_valid[1]),
    .write_complete(write_complete[1]), .busy(busy[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_dq_oe(mem_dq_oe[1]),
    .mem_rdata(mem_rdata[1]), .mem_cs_n(mem_cs_n[1]),
    .mem_oe_n(mem_oe_n[1]), .mem_we_n(mem_we_n[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Pin-level SRAM contents and the word-level reference memory, keyed {dut, halfword addr}.
  logic [15:0] bus_mem[logic [25:0]];
  logic [15:0] ref_mem[logic [25:0]];

  function automatic logic [15:0] dflt(input logic [24:0] a);
    return a[15:0] ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] bus_rd(input int d, input logic [24:0] a);
    logic [25:0] k;
    k = {d[0], a};
    return bus_mem.exists(k) ? bus_mem[k] : dflt(a);
  endfunction

  function automatic logic [15:0] ref_rd(input int d, input logic [24:0] a);
    logic [25:0] k;
    k = {d[0], a};
    return ref_mem.exists(k) ? ref_mem[k] : dflt(a);
  endfunction

  function automatic int ws_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // Bus monitor: SRAM behaviour, strobe beat lengths/addresses, protocol rules, pulse counts.
  int          run[2];
  int          nbeat[2];
  int          beat_len[2][2];
  logic [24:0] beat_addr[2][2];
  logic        beat_we[2][2];
  int          viol[2];
  int          n_valid[2];
  int          n_wc[2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      run[d] = 0; nbeat[d] = 0; viol[d] = 0; n_valid[d] = 0; n_wc[d] = 0;
      mem_rdata[d] = 16'h0;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!mem_cs_n[d] && !mem_we_n[d] && mem_dq_oe[d])
        bus_mem[{d[0], mem_addr[d]}] = mem_wdata[d];
      mem_rdata[d] = bus_rd(d, mem_addr[d]);
      if (!mem_oe_n[d] && !mem_we_n[d]) viol[d]++;
      if (mem_dq_oe[d] && (mem_cs_n[d] || !mem_oe_n[d])) viol[d]++;
      if (!mem_we_n[d] && !mem_dq_oe[d]) viol[d]++;
      if ((!mem_oe_n[d] || !mem_we_n[d]) && mem_cs_n[d]) viol[d]++;
      if (data_valid[d]) n_valid[d]++;
      if (write_complete[d]) n_wc[d]++;
      if (!mem_oe_n[d] || !mem_we_n[d]) begin
        if (run[d] == 0 && nbeat[d] < 2) begin
          beat_addr[d][nbeat[d]] = mem_addr[d];
          beat_we[d][nbeat[d]]   = !mem_we_n[d];
        end
        run[d]++;
      end else if (run[d] > 0) begin
        if (nbeat[d] < 2) beat_len[d][nbeat[d]] = run[d];
        nbeat[d]++;
        run[d] = 0;
      end
    end
  end

  task automatic wait_idle(input int d);
    int t;
    t = 0;
    while (busy[d] && t < 64) begin
      @(negedge clk);
      t++;
    end
    chk("idle_wait", 64'(busy[d]), 64'd0);
  endtask

  // Returns the number of rising edges until a completion pulse is seen (bounded).
  task automatic wait_pulse(input int d, output int k);
    k = 0;
    while (k < 64) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (data_valid[d] || write_complete[d]) break;
    end
  endtask

  // One complete transaction with full checking; called at a negedge.
  task automatic do_txn(input int d, input bit w, input logic [23:0] a,
                        input logic [31:0] wd, input bit hold_extra);
    int k, v0, c0, ws;
    logic [31:0] exp_rd;
    ws = ws_of(d);
    wait_idle(d);
    nbeat[d] = 0;
    v0 = n_valid[d];
    c0 = n_wc[d];
    exp_rd = {ref_rd(d, {a, 1'b0}), ref_rd(d, {a, 1'b1})};
    req_addr[d]  = a;
    req_wdata[d] = wd;
    if (w) req_write[d] = 1'b1; else req_read[d] = 1'b1;
    wait_pulse(d, k);
    chk("latency", 64'(k), 64'(2 * (ws + 2) + 1));
    chk("pulse_valid", 64'(data_valid[d]), 64'(!w));
    chk("pulse_wc", 64'(write_complete[d]), 64'(w));
    if (w) begin
      ref_mem[{d[0], a, 1'b0}] = wd[31:16];
      ref_mem[{d[0], a, 1'b1}] = wd[15:0];
      chk("bus_hi", 64'(bus_rd(d, {a, 1'b0})), 64'(wd[31:16]));
      chk("bus_lo", 64'(bus_rd(d, {a, 1'b1})), 64'(wd[15:0]));
    end else begin
      chk("rd_data", 64'(rd_data[d]), 64'(exp_rd));
    end
    chk("nbeat", 64'(nbeat[d]), 64'd2);
    for (int b = 0; b < 2; b++) begin
      chk("beat_len", 64'(beat_len[d][b]), 64'(ws + 1));
      chk("beat_addr", 64'(beat_addr[d][b]), 64'({a, b[0]}));
      chk("beat_kind", 64'(beat_we[d][b]), 64'(w));
    end
    @(posedge clk); @(negedge clk);
    chk("pulse_drop", 64'(data_valid[d] | write_complete[d]), 64'd0);
    chk("busy_release", 64'(busy[d]), 64'd1);
    if (!w) chk("rd_hold", 64'(rd_data[d]), 64'(exp_rd));
    if (hold_extra) begin
      @(posedge clk); @(negedge clk);
      chk("busy_hold", 64'(busy[d]), 64'd1);
      chk("no_repeat", 64'(data_valid[d] | write_complete[d]), 64'd0);
    end
    req_read[d]  = 1'b0;
    req_write[d] = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("busy_clear", 64'(busy[d]), 64'd0);
    chk("cnt_valid", 64'(n_valid[d] - v0), 64'(!w));
    chk("cnt_wc", 64'(n_wc[d] - c0), 64'(w));
  endtask

  task automatic chk_reset_state(input int d);
    chk("rst_cs_n", 64'(mem_cs_n[d]), 64'd1);
    chk("rst_oe_n", 64'(mem_oe_n[d]), 64'd1);
    chk("rst_we_n", 64'(mem_we_n[d]), 64'd1);
    chk("rst_dq_oe", 64'(mem_dq_oe[d]), 64'd0);
    chk("rst_addr", 64'(mem_addr[d]), 64'd0);
    chk("rst_wdata", 64'(mem_wdata[d]), 64'd0);
    chk("rst_rd_data", 64'(rd_data[d]), 64'd0);
    chk("rst_pulses", 64'(data_valid[d] | write_complete[d]), 64'd0);
    chk("rst_busy", 64'(busy[d]), 64'd0);
  endtask

  // Abort a read during its low-half strobe, then confirm a clean restart.
  task automatic rst_mid(input int d);
    int v0;
    logic [23:0] a;
    wait_idle(d);
    a = 24'($urandom_range(0, 15));
    v0 = n_valid[d];
    req_addr[d] = a;
    req_read[d] = 1'b1;
    @(posedge clk);                         // accept edge
    repeat (ws_of(d) + 2) @(posedge clk);   // now in LO_STROBE
    @(negedge clk);
    chk("in_lo_strobe", 64'(mem_oe_n[d]), 64'd0);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk_reset_state(d);
    rst = 1'b0;
    req_read[d] = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    chk("abort_no_valid", 64'(n_valid[d] - v0), 64'd0);
    do_txn(d, 1'b0, a, 32'h0, 1'b0);
  endtask

  initial begin
    int k;
    logic [31:0] wd;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_addr[d] = '0; req_wdata[d] = '0; req_read[d] = 1'b0; req_write[d] = 1'b0;
    end
    bus_mem[{1'b0, 25'h20}] = 16'hDEAD; ref_mem[{1'b0, 25'h20}] = 16'hDEAD;
    bus_mem[{1'b0, 25'h21}] = 16'hBEEF; ref_mem[{1'b0, 25'h21}] = 16'hBEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state(0);
    chk_reset_state(1);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);

    // Basic read and write.
    do_txn(0, 1'b0, 24'h000010, 32'h0, 1'b0);
    chk("read_deadbeef", 64'(rd_data[0]), 64'h00000000DEADBEEF);
    do_txn(0, 1'b1, 24'h000100, 32'h12345678, 1'b0);
    chk("wr_200", 64'(bus_rd(0, 25'h200)), 64'h1234);
    chk("wr_201", 64'(bus_rd(0, 25'h201)), 64'h5678);

    // Request held one cycle past completion.
    do_txn(0, 1'b1, 24'h000042, $urandom, 1'b1);

    // Back-to-back sequence.
    do_txn(0, 1'b0, 24'h0, 32'h0, 1'b0);
    do_txn(0, 1'b0, 24'h1, 32'h0, 1'b0);
    do_txn(0, 1'b1, 24'h0, 32'hA5A55A5A, 1'b0);
    do_txn(0, 1'b1, 24'h1, 32'hC3C33C3C, 1'b0);
    do_txn(0, 1'b0, 24'h0, 32'h0, 1'b0);

    // Simultaneous read and write: write first, pending read returns the new data.
    wait_idle(0);
    wd = $urandom;
    req_addr[0] = 24'h5; req_wdata[0] = wd;
    req_write[0] = 1'b1; req_read[0] = 1'b1;
    wait_pulse(0, k);
    chk("tie_latency", 64'(k), 64'd9);
    chk("tie_wc_first", 64'(write_complete[0]), 64'd1);
    chk("tie_no_valid", 64'(data_valid[0]), 64'd0);
    ref_mem[{1'b0, 24'h5, 1'b0}] = wd[31:16];
    ref_mem[{1'b0, 24'h5, 1'b1}] = wd[15:0];
    @(posedge clk); @(negedge clk);
    req_write[0] = 1'b0;
    wait_pulse(0, k);
    chk("tie_read_latency", 64'(k), 64'd10);
    chk("tie_read_valid", 64'(data_valid[0]), 64'd1);
    chk("tie_read_data", 64'(rd_data[0]), 64'(wd));
    @(posedge clk); @(negedge clk);
    req_read[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("tie_idle", 64'(busy[0]), 64'd0);

    // Reset in the middle of an access, both wait-state settings.
    rst_mid(0);
    rst_mid(1);

    // Top-of-range address.
    do_txn(1, 1'b1, 24'hFFFFFF, 32'hCAFEF00D, 1'b0);
    do_txn(1, 1'b0, 24'hFFFFFF, 32'h0, 1'b0);
    chk("top_addr_bus", 64'(bus_rd(1, 25'h1FFFFFE)), 64'hCAFE);

    // Randomized mix over a small address pool so reads hit earlier writes.
    for (int i = 0; i < 40; i++) begin
      int d;
      logic [23:0] a;
      d = int'($urandom_range(0, 1));
      a = ($urandom_range(0, 9) == 0) ? 24'hFFFFFF : 24'($urandom_range(0, 7));
      do_txn(d, 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)));
    end

    chk("protocol_ws2", 64'(viol[0]), 64'd0);
    chk("protocol_ws0", 64'(viol[1]), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
